// File: rtl/cpu_loader_if.sv
// Host byte stream, loader memory port and CPU control bundled as one port.
// master is the loader side; slave is the host/memory/CPU side.
interface cpu_loader_if #(
  parameter int addr_width = 9
);
  logic [7:0]            rx_data;
  logic                  rx_valid;
  logic [7:0]            tx_data;
  logic                  tx_valid;
  logic                  tx_ready;
  logic [addr_width-1:0] mem_raddr;
  logic [addr_width-1:0] mem_waddr;
  logic [7:0]            mem_data_in;
  logic                  mem_write;
  logic [7:0]            mem_data_out;
  logic                  cpu_reset;
  logic                  cpu_halt;
  logic                  cpu_halted;
  logic [addr_width-1:0] start_address;
  logic                  bus_owner;

  modport master (
    input  rx_data, rx_valid, tx_ready, mem_data_out, cpu_halted,
    output tx_data, tx_valid, mem_raddr, mem_waddr, mem_data_in, mem_write,
           cpu_reset, cpu_halt, start_address, bus_owner
  );

  modport slave (
    output rx_data, rx_valid, tx_ready, mem_data_out, cpu_halted,
    input  tx_data, tx_valid, mem_raddr, mem_waddr, mem_data_in, mem_write,
           cpu_reset, cpu_halt, start_address, bus_owner
  );
endinterface

// File: rtl/cpu_loader.sv
// Host-driven loader: 'L' writes a program into memory, 'R' starts the CPU,
// and a CPU halt triggers a 64-byte register dump back to the host.
module cpu_loader #(
  parameter int addr_width = 9
) (
  input logic         clk,
  input logic         reset,
  cpu_loader_if.master bus
);

  typedef enum logic [3:0] {
    IDLE, LEN_HI, LEN_LO, LOAD, SA_HI, SA_LO, KICK, RUN,
    DUMP_ADDR, DUMP_WAIT, DUMP_READ, DUMP_TX, ACK
  } state_t;

  localparam logic [7:0] CMD_LOAD = 8'h4C;
  localparam logic [7:0] CMD_RUN  = 8'h52;
  localparam logic [7:0] CMD_HALT = 8'h48;
  localparam logic [7:0] RSP_OK   = 8'h4B;
  localparam logic [7:0] RSP_BAD  = 8'h3F;
  localparam logic [6:0] DUMP_FIRST = 7'd2;
  localparam logic [6:0] DUMP_LAST  = 7'd65;

  state_t                state;
  logic [7:0]            hi_byte;
  logic [15:0]           remaining;
  logic [addr_width-1:0] waddr;
  logic [6:0]            dump_addr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state             <= IDLE;
      hi_byte           <= '0;
      remaining         <= '0;
      waddr             <= '0;
      dump_addr         <= '0;
      bus.cpu_reset     <= 1'b1;
      bus.bus_owner     <= 1'b1;
      bus.cpu_halt      <= 1'b0;
      bus.tx_valid      <= 1'b0;
      bus.tx_data       <= '0;
      bus.mem_write     <= 1'b0;
      bus.mem_raddr     <= '0;
      bus.mem_waddr     <= '0;
      bus.mem_data_in   <= '0;
      bus.start_address <= '0;
    end else begin
      bus.mem_write <= 1'b0;
      unique case (state)
        IDLE: if (bus.rx_valid) begin
          case (bus.rx_data)
            CMD_LOAD: state <= LEN_HI;
            CMD_RUN:  state <= SA_HI;
            default: begin
              bus.tx_data  <= RSP_BAD;
              bus.tx_valid <= 1'b1;
              state        <= ACK;
            end
          endcase
        end
        LEN_HI: if (bus.rx_valid) begin
          hi_byte <= bus.rx_data;
          state   <= LEN_LO;
        end
        LEN_LO: if (bus.rx_valid) begin
          if ({hi_byte, bus.rx_data} == 16'd0) begin
            bus.tx_data  <= RSP_OK;
            bus.tx_valid <= 1'b1;
            state        <= ACK;
          end else begin
            remaining <= {hi_byte, bus.rx_data};
            waddr     <= '0;
            state     <= LOAD;
          end
        end
        // Address wraps naturally; long loads overwrite earlier bytes.
        LOAD: if (bus.rx_valid) begin
          bus.mem_write   <= bus.bus_owner;
          bus.mem_waddr   <= waddr;
          bus.mem_data_in <= bus.rx_data;
          waddr           <= waddr + 1'b1;
          remaining       <= remaining - 16'd1;
          if (remaining == 16'd1) begin
            bus.tx_data  <= RSP_OK;
            bus.tx_valid <= 1'b1;
            state        <= ACK;
          end
        end
        SA_HI: if (bus.rx_valid) begin
          hi_byte <= bus.rx_data;
          state   <= SA_LO;
        end
        SA_LO: if (bus.rx_valid) begin
          bus.start_address <= addr_width'({hi_byte, bus.rx_data});
          bus.cpu_reset     <= 1'b1;
          state             <= KICK;
        end
        KICK: begin
          bus.cpu_reset <= 1'b0;
          bus.bus_owner <= 1'b0;
          state         <= RUN;
        end
        // A halted CPU wins over a late 'H' arriving in the same cycle.
        RUN: begin
          if (bus.cpu_halted) begin
            bus.cpu_halt  <= 1'b0;
            bus.cpu_reset <= 1'b1;
            bus.bus_owner <= 1'b1;
            dump_addr     <= DUMP_FIRST;
            state         <= DUMP_ADDR;
          end else if (bus.rx_valid && bus.rx_data == CMD_HALT) begin
            bus.cpu_halt <= 1'b1;
          end
        end
        DUMP_ADDR: begin
          bus.mem_raddr <= addr_width'(dump_addr);
          state         <= DUMP_WAIT;
        end
        DUMP_WAIT: state <= DUMP_READ;
        DUMP_READ: begin
          bus.tx_data  <= bus.mem_data_out;
          bus.tx_valid <= 1'b1;
          state        <= DUMP_TX;
        end
        DUMP_TX: if (bus.tx_ready) begin
          bus.tx_valid <= 1'b0;
          if (dump_addr == DUMP_LAST) begin
            state <= IDLE;
          end else begin
            dump_addr <= dump_addr + 7'd1;
            state     <= DUMP_ADDR;
          end
        end
        ACK: if (bus.tx_ready) begin
          bus.tx_valid <= 1'b0;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_loader.sv
// Randomized bench for cpu_loader: byte-level command model with expected
// write/tx queues, a per-cycle compare process, and literal pins.
module tb_cpu_loader;
  localparam int AW = 9;
  localparam int MS = 1 << AW;

  typedef struct {
    int         addr;
    logic [7:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cpu_loader_if #(.addr_width(AW)) bus();
  cpu_loader #(.addr_width(AW)) dut (.clk(clk), .reset(rst), .bus(bus));

  int         checks = 0;
  int         errors = 0;
  int         wr_count = 0;
  int         tx_acc = 0;
  int         hold = 0;
  logic [7:0] mem     [MS];
  logic [7:0] ref_mem [MS];
  wr_t        wq[$];
  logic [7:0] txq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic flag(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual=event required=none", name);
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Compare process: every cycle, writes and tx handshakes against the model.
  task automatic monitor();
    logic [7:0] pd;
    logic       ph, pa;
    wr_t        w;
    ph = 1'b0; pa = 1'b0; pd = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        ph = 1'b0; pa = 1'b0;
      end else begin
        if (bus.mem_write) begin
          wr_count++;
          chk("wr_owner", 32'(bus.bus_owner), 32'd1);
          if (wq.size() == 0) flag("wr_unexpected");
          else begin
            w = wq.pop_front();
            chk("wr_addr", 32'(bus.mem_waddr), w.addr);
            chk("wr_data", 32'(bus.mem_data_in), 32'(w.data));
          end
        end
        chk("cpurst_vs_owner", 32'(bus.cpu_reset), 32'(bus.bus_owner));
        if (pa) chk("tx_drop_after_accept", 32'(bus.tx_valid), 32'd0);
        if (ph) begin
          chk("tx_hold_valid", 32'(bus.tx_valid), 32'd1);
          chk("tx_hold_data", 32'(bus.tx_data), 32'(pd));
        end
        if (bus.tx_valid && bus.tx_ready) begin
          tx_acc++;
          if (txq.size() == 0) flag("tx_unexpected");
          else chk("tx_byte", 32'(bus.tx_data), 32'(txq.pop_front()));
        end
        ph = bus.tx_valid && !bus.tx_ready;
        pa = bus.tx_valid && bus.tx_ready;
        pd = bus.tx_data;
      end
    end
  endtask

  task automatic env();
    forever begin
      @(negedge clk);
      if (bus.mem_write && bus.bus_owner) mem[bus.mem_waddr] = bus.mem_data_in;
      bus.mem_data_out = mem[bus.mem_raddr];
    end
  endtask

  task automatic ready_drv();
    forever begin
      @(posedge clk); #1;
      if (hold > 0) begin
        bus.tx_ready = 1'b0;
        hold--;
      end else begin
        bus.tx_ready = ($urandom % 4) != 0;
      end
    end
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    repeat (gap) step();
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    step();
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'($urandom);
  endtask

  task automatic load_byte(input int idx, input logic [7:0] b, input int gap);
    wr_t w;
    w.addr = idx % MS;
    w.data = b;
    wq.push_back(w);
    ref_mem[idx % MS] = b;
    send(b, gap);
  endtask

  task automatic wait_tx_empty(input int bound);
    int n = 0;
    while ((txq.size() != 0 || wq.size() != 0) && n < bound) begin
      step();
      n++;
    end
    if (txq.size() != 0) begin flag("tx_timeout"); txq.delete(); end
    if (wq.size() != 0) begin flag("wr_timeout"); wq.delete(); end
  endtask

  task automatic do_load(input int n, input bit pattern, input int gmax);
    logic [7:0] b;
    send(8'h4C, $urandom % (gmax + 1));
    send(8'(n >> 8), $urandom % (gmax + 1));
    if (n == 0) txq.push_back(8'h4B);
    send(8'(n), $urandom % (gmax + 1));
    for (int i = 0; i < n; i++) begin
      b = pattern ? (8'(i) ^ 8'h5A) : 8'($urandom);
      if (i == n - 1) txq.push_back(8'h4B);
      load_byte(i, b, $urandom % (gmax + 1));
    end
    wait_tx_empty(n * 6 + 60);
  endtask

  task automatic push_dump();
    for (int a = 2; a <= 65; a++) txq.push_back(ref_mem[a]);
  endtask

  task automatic check_rst_vals(input string tag);
    chk({tag, "_cpu_reset"}, 32'(bus.cpu_reset), 32'd1);
    chk({tag, "_bus_owner"}, 32'(bus.bus_owner), 32'd1);
    chk({tag, "_cpu_halt"}, 32'(bus.cpu_halt), 32'd0);
    chk({tag, "_tx_valid"}, 32'(bus.tx_valid), 32'd0);
    chk({tag, "_tx_data"}, 32'(bus.tx_data), 32'd0);
    chk({tag, "_mem_write"}, 32'(bus.mem_write), 32'd0);
    chk({tag, "_mem_raddr"}, 32'(bus.mem_raddr), 32'd0);
    chk({tag, "_mem_waddr"}, 32'(bus.mem_waddr), 32'd0);
    chk({tag, "_mem_data_in"}, 32'(bus.mem_data_in), 32'd0);
    chk({tag, "_start_address"}, 32'(bus.start_address), 32'd0);
  endtask

  task automatic pulse_reset(input string tag);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    check_rst_vals(tag);
    txq.delete();
    wq.delete();
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    step();
  endtask

  initial begin
    int kind;
    logic [7:0] b;
    rst = 1'b0;
    bus.rx_data = '0; bus.rx_valid = 1'b0; bus.tx_ready = 1'b0;
    bus.cpu_halted = 1'b0; bus.mem_data_out = '0;
    for (int i = 0; i < MS; i++) begin
      mem[i] = 8'($urandom);
      ref_mem[i] = mem[i];
    end
    #1 rst = 1'b1;
    #1 check_rst_vals("init");
    fork
      monitor();
      env();
      ready_drv();
    join_none
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    step();

    // Three-byte load with literal destination checks.
    wr_count = 0;
    send(8'h4C, 0); send(8'h00, 0); send(8'h03, 1);
    load_byte(0, 8'hAA, 0);
    load_byte(1, 8'hBB, 2);
    txq.push_back(8'h4B);
    load_byte(2, 8'hCC, 0);
    wait_tx_empty(60);
    chk("l3_write_count", wr_count, 32'd3);
    chk("l3_mem0", 32'(mem[0]), 32'hAA);
    chk("l3_mem1", 32'(mem[1]), 32'hBB);
    chk("l3_mem2", 32'(mem[2]), 32'hCC);

    // Zero-length load.
    wr_count = 0;
    do_load(0, 1'b0, 1);
    chk("l0_write_count", wr_count, 32'd0);

    // Unknown byte, with a byte arriving during ACK that must be ignored.
    hold = 30;
    txq.push_back(8'h3F);
    send(8'h5A, 0);
    send(8'h4C, 0);
    chk("bad_tx_valid", 32'(bus.tx_valid), 32'd1);
    chk("bad_tx_data", 32'(bus.tx_data), 32'h3F);
    hold = 0;
    wait_tx_empty(60);
    wr_count = 0;
    do_load(0, 1'b0, 0);
    chk("ack_ignore_writes", wr_count, 32'd0);

    // Randomized command mix.
    for (int it = 0; it < 10; it++) begin
      kind = $urandom % 3;
      case (kind)
        0: do_load(1 + $urandom % 24, 1'b0, 2);
        1: begin
          b = 8'($urandom);
          if (b == 8'h4C || b == 8'h52) b = 8'h00;
          txq.push_back(8'h3F);
          send(b, $urandom % 3);
          wait_tx_empty(60);
        end
        default: do_load(0, 1'b0, 2);
      endcase
    end

    // Load longer than memory: indices 512..519 overwrite 0..7.
    do_load(520, 1'b1, 0);
    chk("wrap_mem2", 32'(mem[2]), 32'h58);
    chk("wrap_mem7", 32'(mem[7]), 32'h5D);
    chk("wrap_mem8", 32'(mem[8]), 32'h52);

    // Run at 4, then forced halt dumps preloaded 00..3F with a ready stall.
    for (int a = 2; a <= 65; a++) begin
      mem[a] = 8'(a - 2);
      ref_mem[a] = 8'(a - 2);
    end
    send(8'h52, 0); send(8'h00, 1); send(8'h04, 0);
    chk("kick_start_address", 32'(bus.start_address), 32'd4);
    chk("kick_cpu_reset", 32'(bus.cpu_reset), 32'd1);
    step();
    chk("run_cpu_reset", 32'(bus.cpu_reset), 32'd0);
    chk("run_bus_owner", 32'(bus.bus_owner), 32'd0);
    send(8'h4C, 0);
    repeat (5) step();
    chk("run_ignore_halt", 32'(bus.cpu_halt), 32'd0);
    chk("run_ignore_owner", 32'(bus.bus_owner), 32'd0);
    chk("run_ignore_tx", 32'(bus.tx_valid), 32'd0);
    push_dump();
    tx_acc = 0;
    bus.cpu_halted = 1'b1;
    step();
    bus.cpu_halted = 1'b0;
    chk("halted_bus_owner", 32'(bus.bus_owner), 32'd1);
    chk("halted_cpu_reset", 32'(bus.cpu_reset), 32'd1);
    repeat (12) step();
    hold = 10;
    wait_tx_empty(2000);
    chk("dump1_count", tx_acc, 32'd64);
    repeat (10) step();
    chk("dump1_no_trailer", 32'(bus.tx_valid), 32'd0);
    chk("dump1_count_after", tx_acc, 32'd64);

    // Run at 0x123, host halt request, then dump of the model memory.
    send(8'h52, 0); send(8'h01, 0); send(8'h23, 0);
    chk("kick2_start_address", 32'(bus.start_address), 32'h123);
    step();
    send(8'h48, 1);
    chk("halt_req", 32'(bus.cpu_halt), 32'd1);
    repeat (5) step();
    chk("halt_held", 32'(bus.cpu_halt), 32'd1);
    push_dump();
    tx_acc = 0;
    bus.cpu_halted = 1'b1;
    step();
    bus.cpu_halted = 1'b0;
    chk("halt_cleared", 32'(bus.cpu_halt), 32'd0);
    wait_tx_empty(2000);
    chk("dump2_count", tx_acc, 32'd64);

    // Reset in the middle of a dump aborts it.
    send(8'h52, 0); send(8'h00, 0); send(8'h00, 0);
    step();
    push_dump();
    bus.cpu_halted = 1'b1;
    step();
    bus.cpu_halted = 1'b0;
    repeat (20) step();
    pulse_reset("dump_rst");
    for (int i = 0; i < 20; i++) begin
      chk("dump_rst_quiet", 32'(bus.tx_valid), 32'd0);
      step();
    end

    // Reset in the middle of a load keeps written bytes, stops writes.
    wr_count = 0;
    send(8'h4C, 0); send(8'h00, 0); send(8'h0A, 0);
    for (int i = 0; i < 4; i++) load_byte(i, 8'($urandom), $urandom % 2);
    step();
    pulse_reset("load_rst");
    repeat (10) step();
    chk("load_rst_writes", wr_count, 32'd4);
    for (int i = 0; i < 5; i++) chk("load_rst_mem", 32'(mem[i]), 32'(ref_mem[i]));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/cpu_loader.md
CPU_LOADER -- requirements
Module: cpu_loader

Interface
REQ-001 SHALL have parameter addr_width, default 9, giving the memory address width in bits.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: reset is asynchronous and active-high.
REQ-004 SHALL have port rx_data, input, 8 bits: host command byte.
REQ-005 SHALL have port rx_valid, input, 1 bit: one-cycle strobe marking rx_data valid.
REQ-006 SHALL have port tx_data, output, 8 bits: byte sent to the host.
REQ-007 SHALL have port tx_valid, output, 1 bit: tx_data is valid.
REQ-008 SHALL have port tx_ready, input, 1 bit: the transmitter accepts a byte in any cycle where tx_valid and tx_ready are both high.
REQ-009 SHALL have memory port outputs mem_raddr[addr_width], mem_waddr[addr_width], mem_data_in[8] and mem_write[1], plus input mem_data_out[8].
REQ-010 SHALL have port cpu_reset, output, 1 bit: drives the CPU reset.
REQ-011 SHALL have port cpu_halt, output, 1 bit: drives the CPU halt request.
REQ-012 SHALL have port cpu_halted, input, 1 bit: the CPU's halted flag.
REQ-013 SHALL have port start_address, output, addr_width bits: the CPU start address.
REQ-014 SHALL have port bus_owner, output, 1 bit: 1 means the loader owns the memory port, 0 means the CPU owns it (an external mux uses this).

Function
REQ-015 SHALL run an FSM with states IDLE, LEN_HI, LEN_LO, LOAD, SA_HI, SA_LO, KICK, RUN, DUMP_ADDR, DUMP_WAIT, DUMP_READ, DUMP_TX, ACK.
REQ-016 In IDLE, on rx_valid: 0x4C 'L' goes to LEN_HI; 0x52 'R' goes to SA_HI; any other byte queues 0x3F '?' and goes to ACK.
REQ-017 LEN_HI then LEN_LO SHALL capture a 16-bit length N, high byte first. N=0 queues 'K' and goes to ACK; otherwise the FSM enters LOAD with the write address at 0.
REQ-018 In LOAD, each rx_valid SHALL produce exactly one mem_write pulse in the next cycle, with mem_waddr equal to the current address and mem_data_in equal to the byte; the address then increments modulo 2^addr_width.
REQ-019 After the Nth byte is written, the FSM SHALL queue 'K' (0x4B) and go to ACK.
REQ-020 SA_HI then SA_LO SHALL capture a 16-bit value; start_address takes its low addr_width bits.
REQ-021 KICK SHALL drive cpu_reset=1 for exactly 1 cycle with start_address stable, then set cpu_reset=0 and bus_owner=0 and enter RUN.
REQ-022 In RUN, an rx_valid byte 0x48 'H' SHALL set cpu_halt=1, held until cpu_halted; all other bytes are ignored.
REQ-023 In RUN, cpu_halted=1 SHALL clear cpu_halt, set cpu_reset=1 and bus_owner=1, set the dump address to 2, and enter DUMP_ADDR.
REQ-024 Dump SHALL read addresses 2..65 in ascending order (64 bytes: r0..r15, MSB first).
REQ-025 Dump cycle: DUMP_ADDR registers mem_raddr; DUMP_WAIT waits 1 cycle; DUMP_READ captures mem_data_out into tx_data and asserts tx_valid; DUMP_TX holds until accepted.
REQ-026 After the 64th byte is accepted, the FSM SHALL return to IDLE with no trailer byte.
REQ-027 ACK SHALL hold tx_valid with the queued byte until accepted, then return to IDLE.
REQ-028 tx_valid SHALL deassert in the cycle after acceptance; tx_data SHALL NOT change while tx_valid=1 and tx_ready=0.
REQ-029 rx_valid SHALL be ignored in ACK, KICK, and all DUMP states.
REQ-030 mem_write SHALL be asserted only in LOAD, and only while bus_owner=1.
REQ-031 Lengths above 2^addr_width SHALL wrap addresses and overwrite earlier bytes; there is no error.

Reset
REQ-032 When reset is asserted, the block SHALL asynchronously force: state=IDLE, cpu_reset=1, bus_owner=1, cpu_halt=0, tx_valid=0, tx_data=0, mem_write=0, mem_raddr=0, mem_waddr=0, mem_data_in=0, start_address=0, counters=0.
REQ-033 Reset during LOAD SHALL leave already-written bytes intact and perform no further writes.
REQ-034 Reset during a dump SHALL abort it; no further tx_valid until a new command.

Verification
REQ-035 Send 4C 00 03 AA BB CC -> writes AA@0, BB@1, CC@2, one mem_write pulse each, then tx 'K'.
REQ-036 Send 4C 00 00 -> no mem_write, tx 'K'.
REQ-037 Send 52 00 04 -> start_address=4, 1-cycle cpu_reset pulse, bus_owner=0; force cpu_halted=1 with memory 2..65 = 0x00..0x3F -> tx bytes 00..3F in order, then bus_owner=1 and cpu_reset=1.
REQ-038 In RUN, send 48 -> cpu_halt=1 until cpu_halted, then the dump starts.
REQ-039 tx_ready held low 10 cycles during the dump -> tx_data stable throughout, no byte lost or duplicated.
REQ-040 Send 5A -> tx '?'; reset asserted mid-LOAD -> all outputs at reset values within the same cycle.
